// File: rtl/controle_alarme_pkg.sv
// Shared state encoding and saida patterns for the baby-seat alarm controller.
package controle_alarme_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MONITOR    = 3'd1,
    ST_GRACE      = 3'd2,
    ST_ALARM_LOW  = 3'd3,
    ST_ALARM_HIGH = 3'd4,
    ST_SNOOZE     = 3'd5
  } state_t;

  localparam int SAIDA_WARN = 0;
  localparam int SAIDA_BUZZ = 1;
  localparam int SAIDA_HIGH = 2;

  localparam logic [2:0] PAT_OFF    = 3'b000;
  localparam logic [2:0] PAT_GRACE  = 3'(1 << SAIDA_WARN);
  localparam logic [2:0] PAT_LOW    = 3'((1 << SAIDA_WARN) | (1 << SAIDA_BUZZ));
  localparam logic [2:0] PAT_HIGH   = 3'((1 << SAIDA_WARN) | (1 << SAIDA_BUZZ) | (1 << SAIDA_HIGH));
  localparam logic [2:0] PAT_SNOOZE = 3'(1 << SAIDA_WARN);

  function automatic logic [2:0] saida_for(input state_t st);
    logic [2:0] v;
    case (st)
      ST_GRACE:      v = PAT_GRACE;
      ST_ALARM_LOW:  v = PAT_LOW;
      ST_ALARM_HIGH: v = PAT_HIGH;
      ST_SNOOZE:     v = PAT_SNOOZE;
      default:       v = PAT_OFF;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/controle_alarme_param_suav_canal.sv
// One-bit 2-flop synchroniser plus debouncer: a new level is accepted only after
// DEB_CYC consecutive identical synchronised samples.
module suav_canal #(
  parameter int DEB_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEB_CYC - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/controle_alarme_param.sv
// Parametrised baby-seat alarm controller: sensor voting, link supervision,
// escalating alarm with button snooze, internal tick prescaler.
// state      | meaning
// IDLE       | no child detected
// MONITOR    | child present, guardian link alive
// GRACE      | link lost, tolerance window running (warning LED)
// ALARM_LOW  | link lost too long: LED + buzzer
// ALARM_HIGH | escalated: LED + buzzer + remote flag; only ack or absence clears
// SNOOZE     | silenced by button for SNOOZE_TICKS
module controle_alarme_param
  import controle_alarme_pkg::*;
#(
  parameter int N_SENS       = 2,
  parameter int MIN_VOTES    = 1,
  parameter int DEB_CYC      = 16,
  parameter int TICK_DIV     = 50_000_000,
  parameter int GRACE_TICKS  = 10,
  parameter int ESC_TICKS    = 30,
  parameter int SNOOZE_TICKS = 60
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_SENS-1:0] i_crianca,
  input  logic              i_communication,
  input  logic              i_button,
  output logic [2:0]        o_saida,
  output logic              o_presenca,
  output logic              o_led_link,
  output logic [N_SENS-1:0] o_led_sens,
  output logic [2:0]        o_estado
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam int T_GE  = (GRACE_TICKS > ESC_TICKS) ? GRACE_TICKS : ESC_TICKS;
  localparam int T_MAX = (T_GE > SNOOZE_TICKS) ? T_GE : SNOOZE_TICKS;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] T_GRACE  = TW'(GRACE_TICKS);
  localparam logic [TW-1:0] T_ESC    = TW'(ESC_TICKS);
  localparam logic [TW-1:0] T_SNOOZE = TW'(SNOOZE_TICKS);
  localparam int VW = $clog2(N_SENS + 1);
  localparam logic [VW-1:0] V_MIN = VW'(MIN_VOTES);

  logic [N_SENS-1:0] w_sens_deb;
  logic              w_btn_deb;
  logic              w_ack;
  logic              w_tick;
  logic              w_link;
  logic [VW-1:0]     w_votes;
  state_t            w_next;

  logic              r_link_s1;
  logic              r_link_s2;
  logic              r_btn_prev;
  logic              r_presenca;
  logic [PW-1:0]     r_presc;
  logic [TW-1:0]     r_cnt;
  state_t            r_state;
  logic [2:0]        r_saida;

  for (genvar g = 0; g < N_SENS; g++) begin : g_sens
    suav_canal #(.DEB_CYC(DEB_CYC)) u_suav (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_async (i_crianca[g]),
      .o_level (w_sens_deb[g])
    );
  end

  suav_canal #(.DEB_CYC(DEB_CYC)) u_suav_btn (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_button),
    .o_level (w_btn_deb)
  );

  always_comb begin
    w_votes = '0;
    for (int i = 0; i < N_SENS; i++) w_votes = w_votes + VW'(w_sens_deb[i]);
  end

  assign w_ack  = w_btn_deb & ~r_btn_prev;
  assign w_tick = (r_presc == P_LAST);
  assign w_link = r_link_s2;

  // Absence overrides every state; ack outranks link return in ALARM_LOW.
  always_comb begin
    w_next = r_state;
    if (!r_presenca) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:       w_next = ST_MONITOR;
        ST_MONITOR:    if (!w_link) w_next = ST_GRACE;
        ST_GRACE:      if (w_link) w_next = ST_MONITOR;
                       else if (r_cnt == T_GRACE) w_next = ST_ALARM_LOW;
        ST_ALARM_LOW:  if (w_ack) w_next = ST_SNOOZE;
                       else if (w_link) w_next = ST_MONITOR;
                       else if (r_cnt == T_ESC) w_next = ST_ALARM_HIGH;
        ST_ALARM_HIGH: if (w_ack) w_next = ST_SNOOZE;
        ST_SNOOZE:     if (r_cnt == T_SNOOZE) w_next = w_link ? ST_MONITOR : ST_GRACE;
        default:       w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_link_s1  <= 1'b0;
      r_link_s2  <= 1'b0;
      r_btn_prev <= 1'b0;
      r_presenca <= 1'b0;
      r_presc    <= '0;
      r_cnt      <= '0;
      r_state    <= ST_IDLE;
      r_saida    <= PAT_OFF;
    end else begin
      r_link_s1  <= i_communication;
      r_link_s2  <= r_link_s1;
      r_btn_prev <= w_btn_deb;
      r_presenca <= (w_votes >= V_MIN);
      r_presc    <= w_tick ? '0 : r_presc + 1'b1;
      r_state    <= w_next;
      r_saida    <= saida_for(r_state);
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_tick && (r_cnt != {TW{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_saida    = r_saida;
  assign o_presenca = r_presenca;
  assign o_led_link = r_link_s2;
  assign o_led_sens = w_sens_deb;
  assign o_estado   = r_state;

endmodule

// File: tb/tb_controle_alarme_param.sv
// Bench for controle_alarme_param: directed scenarios plus randomized stimulus
// checked each cycle against a window/timestamp-based behavioural model.
module tb_controle_alarme_param;

  localparam int N_SENS = 3, MIN_VOTES = 2, DEB_CYC = 4, TICK_DIV = 10;
  localparam int GRACE_TICKS = 3, ESC_TICKS = 2, SNOOZE_TICKS = 2;
  localparam int S_IDLE = 0, S_MON = 1, S_GRACE = 2, S_LOW = 3, S_HIGH = 4, S_SNZ = 5;
  localparam int H = DEB_CYC + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  crianca = 3'b000;
  logic        comm = 1'b0;
  logic        button = 1'b0;
  logic [2:0]  o_saida;
  logic        o_presenca;
  logic        o_led_link;
  logic [2:0]  o_led_sens;
  logic [2:0]  o_estado;

  int n_checks = 0;
  int n_err = 0;

  controle_alarme_param #(
    .N_SENS(N_SENS), .MIN_VOTES(MIN_VOTES), .DEB_CYC(DEB_CYC), .TICK_DIV(TICK_DIV),
    .GRACE_TICKS(GRACE_TICKS), .ESC_TICKS(ESC_TICKS), .SNOOZE_TICKS(SNOOZE_TICKS)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_crianca(crianca), .i_communication(comm),
    .i_button(button), .o_saida(o_saida), .o_presenca(o_presenca),
    .o_led_link(o_led_link), .o_led_sens(o_led_sens), .o_estado(o_estado)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference model: raw-sample history windows, edge/tick counts, timestamps.
  int       m_state, m_edges, m_ticks, m_entry;
  bit [3:0] m_lvl;
  bit       m_btn_prev, m_pres, m_link;
  bit [2:0] m_saida;
  bit [3:0] m_hist [H];
  bit       m_lhist [2];

  function automatic bit [2:0] pat(input int st);
    case (st)
      S_GRACE, S_SNZ: return 3'b001;
      S_LOW:          return 3'b011;
      S_HIGH:         return 3'b111;
      default:        return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_edges = 0; m_ticks = 0; m_entry = 0;
    m_lvl = '0; m_btn_prev = 0; m_pres = 0; m_link = 0; m_saida = '0;
    for (int k = 0; k < H; k++) m_hist[k] = '0;
    m_lhist[0] = 0; m_lhist[1] = 0;
  endtask

  task automatic model_step();
    bit ack, tick, diff;
    int cnt, nst;
    bit [3:0] nl;
    m_edges++;
    tick = (m_edges % TICK_DIV == 0);
    ack  = m_lvl[3] && !m_btn_prev;
    cnt  = m_ticks - m_entry;
    nst  = m_state;
    if (!m_pres) nst = S_IDLE;
    else case (m_state)
      S_IDLE:  nst = S_MON;
      S_MON:   if (!m_link) nst = S_GRACE;
      S_GRACE: if (m_link) nst = S_MON; else if (cnt == GRACE_TICKS) nst = S_LOW;
      S_LOW:   if (ack) nst = S_SNZ; else if (m_link) nst = S_MON;
               else if (cnt == ESC_TICKS) nst = S_HIGH;
      S_HIGH:  if (ack) nst = S_SNZ;
      S_SNZ:   if (cnt == SNOOZE_TICKS) nst = m_link ? S_MON : S_GRACE;
      default: nst = S_IDLE;
    endcase
    m_saida    = pat(m_state);
    m_pres     = ($countones(m_lvl[2:0]) >= MIN_VOTES);
    m_btn_prev = m_lvl[3];
    for (int k = H - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = {button, crianca};
    nl = m_lvl;
    for (int ch = 0; ch < 4; ch++) begin
      diff = 1;
      for (int k = 2; k < H; k++) if (m_hist[k][ch] == m_lvl[ch]) diff = 0;
      if (diff) nl[ch] = ~m_lvl[ch];
    end
    m_lvl = nl;
    m_lhist[1] = m_lhist[0];
    m_lhist[0] = comm;
    m_link = m_lhist[1];
    if (tick) m_ticks++;
    if (nst != m_state) begin
      m_state = nst;
      m_entry = m_ticks;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic run_until(input int st, input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (o_estado == st[2:0]) begin ok = 1; break; end
      step();
    end
    if (o_estado == st[2:0]) ok = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; crianca = 3'b111; comm = 0; button = 0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (o_saida !== 3'b000 || o_estado !== 3'd0 || o_presenca !== 1'b0 || o_led_link !== 1'b0) begin
        n_err++;
        $display("FAIL reset_outputs saida=%b estado=%0d presenca=%b link=%b required 000/0/0/0",
                 o_saida, o_estado, o_presenca, o_led_link);
      end
    end
    crianca = 3'b000; comm = 1;
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (o_presenca !== 1'b0 || o_estado !== 3'd0) begin
        n_err++;
        $display("FAIL post_reset_idle presenca=%b estado=%0d required 0/0", o_presenca, o_estado);
      end
    end
  endtask

  task automatic test_debounce();
    crianca = 3'b001;
    repeat (3) step();
    crianca = 3'b000;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (o_led_sens !== 3'b000) begin
        n_err++;
        $display("FAIL glitch_filtered led_sens=%b required 000", o_led_sens);
      end
    end
    crianca = 3'b001;
    repeat (5) step();
    n_checks++;
    if (o_led_sens[0] !== 1'b0) begin
      n_err++;
      $display("FAIL deb_early led_sens0=%b required 0 at cycle 5", o_led_sens[0]);
    end
    step();
    n_checks++;
    if (o_led_sens[0] !== 1'b1) begin
      n_err++;
      $display("FAIL deb_latency led_sens0=%b required 1 at cycle 6", o_led_sens[0]);
    end
    repeat (10) step();
    n_checks++;
    if (o_presenca !== 1'b0 || o_led_sens !== 3'b001) begin
      n_err++;
      $display("FAIL one_vote presenca=%b led_sens=%b required 0/001", o_presenca, o_led_sens);
    end
  endtask

  task automatic test_voting();
    crianca = 3'b011;
    repeat (7) step();
    n_checks++;
    if (o_presenca !== 1'b1 || o_estado !== 3'd0) begin
      n_err++;
      $display("FAIL two_votes presenca=%b estado=%0d required 1/0", o_presenca, o_estado);
    end
    step();
    n_checks++;
    if (o_estado !== 3'd1) begin
      n_err++;
      $display("FAIL idle_to_monitor estado=%0d required 1", o_estado);
    end
  endtask

  task automatic test_escalation();
    bit ok;
    comm = 0;
    repeat (3) step();
    n_checks++;
    if (o_estado !== 3'd2) begin
      n_err++;
      $display("FAIL enter_grace estado=%0d required 2", o_estado);
    end
    step();
    n_checks++;
    if (o_saida !== 3'b001) begin
      n_err++;
      $display("FAIL grace_saida saida=%b required 001", o_saida);
    end
    run_until(S_LOW, 60, ok);
    n_checks++;
    if (!ok || m_state != S_LOW) begin
      n_err++;
      $display("FAIL grace_to_low estado=%0d model=%0d required 3", o_estado, m_state);
    end
    step();
    n_checks++;
    if (o_saida !== 3'b011) begin
      n_err++;
      $display("FAIL low_saida saida=%b required 011", o_saida);
    end
    run_until(S_HIGH, 40, ok);
    n_checks++;
    if (!ok || m_state != S_HIGH) begin
      n_err++;
      $display("FAIL low_to_high estado=%0d model=%0d required 4", o_estado, m_state);
    end
    step();
    n_checks++;
    if (o_saida !== 3'b111) begin
      n_err++;
      $display("FAIL high_saida saida=%b required 111", o_saida);
    end
    comm = 1;
    repeat (10) step();
    n_checks++;
    if (o_estado !== 3'd4 || o_saida !== 3'b111) begin
      n_err++;
      $display("FAIL high_sticky estado=%0d saida=%b required 4/111", o_estado, o_saida);
    end
  endtask

  task automatic test_snooze();
    bit ok;
    comm = 0;
    repeat (3) step();
    button = 1;
    repeat (6) step();
    n_checks++;
    if (o_estado !== 3'd4) begin
      n_err++;
      $display("FAIL ack_early estado=%0d required 4", o_estado);
    end
    step();
    n_checks++;
    if (o_estado !== 3'd5) begin
      n_err++;
      $display("FAIL ack_snooze estado=%0d required 5", o_estado);
    end
    step();
    n_checks++;
    if (o_saida !== 3'b001) begin
      n_err++;
      $display("FAIL snooze_saida saida=%b required 001", o_saida);
    end
    repeat (12) step();
    button = 0;
    run_until(S_GRACE, 40, ok);
    n_checks++;
    if (!ok || m_state != S_GRACE) begin
      n_err++;
      $display("FAIL snooze_to_grace estado=%0d model=%0d required 2", o_estado, m_state);
    end
  endtask

  task automatic test_priority();
    bit ok;
    run_until(S_LOW, 60, ok);
    button = 1;
    repeat (4) step();
    comm = 1;
    repeat (2) step();
    n_checks++;
    if (!ok || o_estado !== 3'd3) begin
      n_err++;
      $display("FAIL prio_setup estado=%0d required 3", o_estado);
    end
    step();
    n_checks++;
    if (o_estado !== 3'd5) begin
      n_err++;
      $display("FAIL ack_beats_link estado=%0d required 5", o_estado);
    end
    button = 0;
    run_until(S_MON, 40, ok);
    comm = 0;
    run_until(S_HIGH, 100, ok);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL reach_high estado=%0d required 4", o_estado);
    end
    crianca = 3'b000;
    repeat (7) step();
    n_checks++;
    if (o_estado !== 3'd4) begin
      n_err++;
      $display("FAIL absence_early estado=%0d required 4", o_estado);
    end
    step();
    n_checks++;
    if (o_estado !== 3'd0) begin
      n_err++;
      $display("FAIL absence_idle estado=%0d required 0", o_estado);
    end
    step();
    n_checks++;
    if (o_saida !== 3'b000) begin
      n_err++;
      $display("FAIL absence_saida saida=%b required 000", o_saida);
    end
    crianca = 3'b011;
    run_until(S_LOW, 150, ok);
    step();
    n_checks++;
    if (!ok || o_saida !== 3'b011) begin
      n_err++;
      $display("FAIL pre_reset_low estado=%0d saida=%b required 3/011", o_estado, o_saida);
    end
    rst_n = 0;
    #1;
    n_checks++;
    if (o_saida !== 3'b000 || o_estado !== 3'd0 || o_presenca !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset saida=%b estado=%0d presenca=%b required 000/0/0",
               o_saida, o_estado, o_presenca);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (o_presenca !== 1'b0) begin
        n_err++;
        $display("FAIL redebounce presenca=%b required 0 at cycle %0d", o_presenca, i + 1);
      end
    end
    step();
    n_checks++;
    if (o_presenca !== 1'b1) begin
      n_err++;
      $display("FAIL redebounce_rise presenca=%b required 1", o_presenca);
    end
  endtask

  task automatic test_random();
    int dur;
    for (int seg = 0; seg < 160; seg++) begin
      crianca = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) comm = ~comm;
      button = ($urandom_range(0, 3) == 0);
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 70) : $urandom_range(1, 10);
      for (int c = 0; c < dur; c++) begin
        step();
        n_checks++;
        if (o_saida !== m_saida || o_estado !== m_state[2:0] || o_presenca !== m_pres ||
            o_led_link !== m_link || o_led_sens !== m_lvl[2:0]) begin
          n_err++;
          $display("FAIL random seg=%0d got saida=%b estado=%0d pres=%b link=%b sens=%b required %b/%0d/%b/%b/%b",
                   seg, o_saida, o_estado, o_presenca, o_led_link, o_led_sens,
                   m_saida, m_state, m_pres, m_link, m_lvl[2:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_voting();
    test_escalation();
    test_snooze();
    test_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
